// File: rtl/decode_pkg.sv
// Shared types for the registered decode stage: opcode/subop encodings,
// the ALU operation enum and the control bundle carried to execute.
package decode_pkg;

    // Bundle fields are sized for the largest supported configuration.
    localparam int ADDR_MAX_W = 8;
    localparam int IMM_MAX_W  = 8;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_MEM   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_ADDI  = 3'b011;
    localparam logic [2:0] OP_TR    = 3'b100;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] SUB_AND = 2'b00;
    localparam logic [1:0] SUB_SLT = 2'b01;
    localparam logic [1:0] SUB_OR  = 2'b10;
    localparam logic [1:0] SUB_JR  = 2'b11;

    localparam logic [1:0] SUB_LW  = 2'b00;
    localparam logic [1:0] SUB_SW  = 2'b01;
    localparam logic [1:0] SUB_SRL = 2'b10;
    localparam logic [1:0] SUB_SRA = 2'b11;

    typedef enum logic [2:0] {
        ALU_AND  = 3'd0,
        ALU_SLT  = 3'd1,
        ALU_OR   = 3'd2,
        ALU_ADD  = 3'd3,
        ALU_SRL  = 3'd4,
        ALU_SRA  = 3'd5,
        ALU_PASS = 3'd6
    } alu_op_e;

    typedef struct packed {
        alu_op_e               alu_op;
        logic [ADDR_MAX_W-1:0] rs;
        logic [ADDR_MAX_W-1:0] rt;
        logic [ADDR_MAX_W-1:0] rd;
        logic [IMM_MAX_W-1:0]  imm;
        logic                  reg_read;
        logic                  reg_write;
        logic                  sel_imm;
        logic                  branch;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem2reg;
        logic                  illegal;
    } ctrl_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side signals of the decode stage; the stage uses the
// slave view, its environment the master view.
interface decode_stage_if #(
    parameter int RA          = 4,
    parameter int INSTR_WIDTH = 9,
    parameter int IMM_WIDTH   = 3,
    parameter int CNT_WIDTH   = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [2:0]             alu_op;
    logic [RA-1:0]          rs_addr;
    logic [RA-1:0]          rt_addr;
    logic [RA-1:0]          rd_addr;
    logic [IMM_WIDTH-1:0]   imm;
    logic                   reg_read;
    logic                   reg_write;
    logic                   sel_imm;
    logic                   branch;
    logic                   mem_read;
    logic                   mem_write;
    logic                   mem2reg;
    logic                   illegal;
    logic                   halted;
    logic [CNT_WIDTH-1:0]   retired;

    modport master (
        output in_valid, instruction, flush, out_ready,
        input  in_ready, out_valid, alu_op, rs_addr, rt_addr, rd_addr, imm,
               reg_read, reg_write, sel_imm, branch, mem_read, mem_write,
               mem2reg, illegal, halted, retired
    );

    modport slave (
        input  in_valid, instruction, flush, out_ready,
        output in_ready, out_valid, alu_op, rs_addr, rt_addr, rd_addr, imm,
               reg_read, reg_write, sel_imm, branch, mem_read, mem_write,
               mem2reg, illegal, halted, retired
    );

endinterface

// File: rtl/decode_comb.sv
// Pure combinational instruction decoder: instruction word in, control
// bundle out. Register addresses are formed at RA width and clamped.
module decode_comb
    import decode_pkg::*;
#(
    parameter int NUM_REGS    = 12,
    parameter int INSTR_WIDTH = 9
) (
    input  logic [INSTR_WIDTH-1:0] instruction,
    output ctrl_t                  ctrl
);
    localparam int RA = $clog2(NUM_REGS);

    logic [2:0] op;
    logic [5:0] f;

    assign op = instruction[INSTR_WIDTH-1 -: 3];
    assign f  = instruction[5:0];

    // Sums wrap at RA bits first, then anything past the last register clamps to it.
    function automatic logic [ADDR_MAX_W-1:0] reg_addr(input logic [RA-1:0] base,
                                                       input logic [RA-1:0] offs);
        logic [RA-1:0] sum;
        sum = base + offs;
        if ({1'b0, sum} > (RA+1)'(NUM_REGS - 1)) begin
            sum = RA'(NUM_REGS - 1);
        end
        return ADDR_MAX_W'(sum);
    endfunction

    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_AND;
        ctrl.rs     = reg_addr(RA'(f[5:4]), RA'(4));
        ctrl.rt     = reg_addr(RA'(f[3:2]), RA'(0));
        ctrl.rd     = reg_addr(RA'(11), RA'(0));

        case (op)
            OP_RTYPE: begin
                ctrl.reg_read = 1'b1;
                case (f[1:0])
                    SUB_AND: begin ctrl.alu_op = ALU_AND; ctrl.reg_write = 1'b1; end
                    SUB_SLT: begin ctrl.alu_op = ALU_SLT; ctrl.reg_write = 1'b1; end
                    SUB_OR:  begin ctrl.alu_op = ALU_OR;  ctrl.reg_write = 1'b1; end
                    default: begin ctrl.alu_op = ALU_PASS; ctrl.branch = 1'b1; end
                endcase
            end
            OP_MEM: begin
                ctrl.reg_read = 1'b1;
                case (f[1:0])
                    SUB_LW: begin
                        ctrl.alu_op    = ALU_PASS;
                        ctrl.mem_read  = 1'b1;
                        ctrl.mem2reg   = 1'b1;
                        ctrl.reg_write = 1'b1;
                        ctrl.rd        = reg_addr(RA'(f[5:4]), RA'(4));
                    end
                    SUB_SW: begin
                        ctrl.alu_op    = ALU_PASS;
                        ctrl.mem_write = 1'b1;
                    end
                    SUB_SRL: begin
                        ctrl.alu_op    = ALU_SRL;
                        ctrl.reg_write = 1'b1;
                    end
                    default: begin
                        ctrl.alu_op    = ALU_SRA;
                        ctrl.reg_write = 1'b1;
                    end
                endcase
            end
            OP_ADD: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.reg_read  = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.rd        = reg_addr(RA'(f[1:0]), RA'(8));
            end
            OP_ADDI: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.imm       = IMM_MAX_W'(f[1:0]);
                ctrl.sel_imm   = 1'b1;
                ctrl.reg_read  = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.rd        = reg_addr(RA'(f[5:4]), RA'(4));
            end
            OP_TR: begin
                ctrl.alu_op    = ALU_PASS;
                ctrl.rs        = reg_addr(RA'(f[5:3]), RA'(0));
                ctrl.rd        = reg_addr(RA'(f[2:0]), RA'(4));
                ctrl.reg_read  = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_HALT: begin
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute: valid/ready handshake,
// one-entry output register, load-use stall, sticky halt, flush, retired count.
module decode_stage
    import decode_pkg::*;
#(
    parameter int NUM_REGS    = 12,
    parameter int INSTR_WIDTH = 9,
    parameter int IMM_WIDTH   = 3,
    parameter int LOAD_DELAY  = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    decode_stage_if.slave bus
);
    localparam int RA = $clog2(NUM_REGS);

    ctrl_t                 dec;
    ctrl_t                 ctrl_q, ctrl_d;
    logic                  out_valid_q, out_valid_d;
    logic [2:0]            stall_q, stall_d;
    logic [ADDR_MAX_W-1:0] lw_rd_q, lw_rd_d;
    logic                  halted_q, halted_d;
    logic [CNT_WIDTH-1:0]  retired_q, retired_d;

    logic                  hazard;
    logic                  in_ready;
    logic                  accept;
    logic                  is_halt;

    decode_comb #(
        .NUM_REGS    (NUM_REGS),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_decode_comb (
        .instruction (bus.instruction),
        .ctrl        (dec)
    );

    // Flush also drops in_ready so fetch never sees a handshake that was discarded.
    always_comb begin
        hazard   = (stall_q != '0) && dec.reg_read &&
                   ((dec.rs == lw_rd_q) || ((dec.rt == lw_rd_q) && !dec.sel_imm));
        in_ready = !halted_q && !hazard && !bus.flush && (!out_valid_q || bus.out_ready);
        accept   = bus.in_valid && in_ready;
        is_halt  = (bus.instruction[INSTR_WIDTH-1 -: 3] == OP_HALT);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        stall_d     = stall_q;
        lw_rd_d     = lw_rd_q;
        halted_d    = halted_q;
        retired_d   = retired_q;

        if (out_valid_q && bus.out_ready) begin
            retired_d = retired_q + CNT_WIDTH'(1);
        end
        if (stall_q != '0) begin
            stall_d = stall_q - 3'd1;
        end

        if (bus.flush) begin
            out_valid_d = 1'b0;
            stall_d     = '0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            ctrl_d      = dec;
            if (dec.mem_read) begin
                stall_d = 3'(LOAD_DELAY);
                lw_rd_d = dec.rd;
            end
            if (is_halt) begin
                halted_d = 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            stall_q     <= '0;
            lw_rd_q     <= '0;
            halted_q    <= 1'b0;
            retired_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            stall_q     <= stall_d;
            lw_rd_q     <= lw_rd_d;
            halted_q    <= halted_d;
            retired_q   <= retired_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_op    = ctrl_q.alu_op;
    assign bus.rs_addr   = ctrl_q.rs[RA-1:0];
    assign bus.rt_addr   = ctrl_q.rt[RA-1:0];
    assign bus.rd_addr   = ctrl_q.rd[RA-1:0];
    assign bus.imm       = ctrl_q.imm[IMM_WIDTH-1:0];
    assign bus.reg_read  = ctrl_q.reg_read;
    assign bus.reg_write = ctrl_q.reg_write;
    assign bus.sel_imm   = ctrl_q.sel_imm;
    assign bus.branch    = ctrl_q.branch;
    assign bus.mem_read  = ctrl_q.mem_read;
    assign bus.mem_write = ctrl_q.mem_write;
    assign bus.mem2reg   = ctrl_q.mem2reg;
    assign bus.illegal   = ctrl_q.illegal;
    assign bus.halted    = halted_q;
    assign bus.retired   = retired_q;

    // Upper bits of the wide bundle fields are always zero in this configuration.
    logic unused_bits;
    assign unused_bits = ^{ctrl_q.rs, ctrl_q.rt, ctrl_q.rd, ctrl_q.imm};

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed steps followed by random traffic, all
// checked against a behavioural model of the decode rules and handshake.
module tb_decode_stage;

    localparam int NUM_REGS    = 12;
    localparam int RA          = 4;
    localparam int INSTR_WIDTH = 9;
    localparam int IMM_WIDTH   = 3;
    localparam int LOAD_DELAY  = 1;
    localparam int CNT_WIDTH   = 16;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    decode_stage_if #(
        .RA          (RA),
        .INSTR_WIDTH (INSTR_WIDTH),
        .IMM_WIDTH   (IMM_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH)
    ) bus ();

    decode_stage #(
        .NUM_REGS    (NUM_REGS),
        .INSTR_WIDTH (INSTR_WIDTH),
        .IMM_WIDTH   (IMM_WIDTH),
        .LOAD_DELAY  (LOAD_DELAY),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        int alu;
        int rs;
        int rt;
        int rd;
        int imm;
        bit rr, rw, si, br, mr, mw, m2r, ill;
    } exp_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    bit   m_valid;
    bit   m_halted;
    exp_t m_bundle;
    int   m_stall;
    int   m_lwrd;
    int   m_retired;
    logic last_ready;

    function automatic int clamp(input int x);
        return (x >= NUM_REGS) ? NUM_REGS - 1 : x;
    endfunction

    function automatic exp_t model_decode(input logic [8:0] w);
        exp_t e;
        int   op, a, b, c;
        op = int'(w[8:6]);
        a  = int'(w[5:4]);
        b  = int'(w[3:2]);
        c  = int'(w[1:0]);
        e    = '0;
        e.rs = clamp(a + 4);
        e.rt = clamp(b);
        e.rd = clamp(11);
        case (op)
            0: begin
                e.rr = 1;
                if (c == 3) begin e.alu = 6; e.br = 1; end
                else begin e.alu = c; e.rw = 1; end
            end
            1: begin
                e.rr  = 1;
                e.alu = (c < 2) ? 6 : c + 2;
                e.rw  = (c != 1);
                e.mr  = (c == 0);
                e.m2r = (c == 0);
                e.mw  = (c == 1);
                if (c == 0) e.rd = clamp(a + 4);
            end
            2: begin e.alu = 3; e.rr = 1; e.rw = 1; e.rd = clamp(c + 8); end
            3: begin
                e.alu = 3; e.imm = c; e.si = 1; e.rr = 1; e.rw = 1;
                e.rd  = clamp(a + 4);
            end
            4: begin
                e.alu = 6; e.rr = 1; e.rw = 1;
                e.rs  = clamp(int'(w[5:3]));
                e.rd  = clamp(int'(w[2:0]) + 4);
            end
            5, 6: e.ill = 1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [63:0] pack(input exp_t e);
        return 64'({e.alu[2:0], e.rs[3:0], e.rt[3:0], e.rd[3:0], e.imm[2:0],
                    e.rr, e.rw, e.si, e.br, e.mr, e.mw, e.m2r, e.ill});
    endfunction

    function automatic logic [63:0] dut_bundle();
        return 64'({bus.alu_op, bus.rs_addr, bus.rt_addr, bus.rd_addr, bus.imm,
                    bus.reg_read, bus.reg_write, bus.sel_imm, bus.branch,
                    bus.mem_read, bus.mem_write, bus.mem2reg, bus.illegal});
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid   = 0;
        m_halted  = 0;
        m_bundle  = '0;
        m_stall   = 0;
        m_lwrd    = 0;
        m_retired = 0;
    endtask

    // One clock: drive, check in_ready, advance the model, check registered outputs.
    task automatic cycle(input bit v, input logic [8:0] ins, input bit ordy, input bit fl);
        exp_t e;
        bit   reads, exp_ready, acc;
        bus.in_valid    = v;
        bus.instruction = ins;
        bus.out_ready   = ordy;
        bus.flush       = fl;
        #1;
        e         = model_decode(ins);
        reads     = e.rr && ((e.rs == m_lwrd) || ((e.rt == m_lwrd) && !e.si));
        exp_ready = !m_halted && !((m_stall > 0) && reads) && !fl && (!m_valid || ordy);
        last_ready = bus.in_ready;
        check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
        acc = v && exp_ready;
        @(posedge clk);
        if (m_valid && ordy) m_retired = (m_retired + 1) % 65536;
        if (m_stall > 0) m_stall--;
        if (fl) begin
            m_valid = 0;
            m_stall = 0;
        end else if (acc) begin
            m_valid  = 1;
            m_bundle = e;
            if (e.mr) begin
                m_stall = LOAD_DELAY;
                m_lwrd  = e.rd;
            end
            if (ins[8:6] == 3'b111) m_halted = 1;
        end else if (ordy) begin
            m_valid = 0;
        end
        #1;
        check("out_valid", 64'(bus.out_valid), 64'(m_valid));
        check("halted", 64'(bus.halted), 64'(m_halted));
        check("retired", 64'(bus.retired), 64'(m_retired));
        if (m_valid) check("bundle", dut_bundle(), pack(m_bundle));
    endtask

    localparam logic [8:0] I_ADD   = 9'b010_01_10_11;
    localparam logic [8:0] I_LW    = 9'b001_10_00_00;
    localparam logic [8:0] I_DEP   = 9'b010_10_01_00;
    localparam logic [8:0] I_IND   = 9'b010_00_01_00;
    localparam logic [8:0] I_ADDI  = 9'b011_01_00_10;
    localparam logic [8:0] I_TR    = 9'b100_101_011;
    localparam logic [8:0] I_ILL   = 9'b101_000000;
    localparam logic [8:0] I_HALT  = 9'b111_000000;

    initial begin
        logic [8:0] rnd_ins;

        reset_n         = 1'b0;
        bus.in_valid    = 1'b0;
        bus.instruction = '0;
        bus.out_ready   = 1'b0;
        bus.flush       = 1'b0;
        model_reset();
        #12;
        check("reset_state", 64'({bus.out_valid, bus.halted, bus.retired}), 64'(0));
        check("reset_bundle", dut_bundle(), 64'(0));
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic ADD with latency 1, then retired counts its delivery.
        cycle(1, I_ADD, 1, 0);
        check("add_alu", 64'(bus.alu_op), 64'(3));
        check("add_rs", 64'(bus.rs_addr), 64'(5));
        check("add_rt", 64'(bus.rt_addr), 64'(2));
        check("add_rd", 64'(bus.rd_addr), 64'(11));
        check("add_regwrite", 64'(bus.reg_write), 64'(1));
        cycle(0, '0, 1, 0);
        check("add_retired", 64'(bus.retired), 64'(1));

        // Load-use: dependent ADD blocked one cycle, independent ADD goes straight through.
        cycle(1, I_LW, 1, 0);
        cycle(1, I_DEP, 1, 0);
        check("lw_use_block", 64'(last_ready), 64'(0));
        cycle(1, I_DEP, 1, 0);
        check("lw_use_release", 64'(last_ready), 64'(1));
        cycle(1, I_LW, 1, 0);
        cycle(1, I_IND, 1, 0);
        check("lw_indep", 64'(last_ready), 64'(1));

        // Back-pressure holds the bundle.
        cycle(1, I_ADDI, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, I_TR, 0, 0);
            check("hold_ready", 64'(last_ready), 64'(0));
            check("hold_alu", 64'(bus.alu_op), 64'(3));
            check("hold_imm", 64'(bus.imm), 64'(2));
            check("hold_selimm", 64'(bus.sel_imm), 64'(1));
        end
        cycle(1, I_TR, 1, 0);
        cycle(0, '0, 1, 0);

        // Flush right after an LW.
        cycle(1, I_LW, 1, 0);
        cycle(0, '0, 1, 1);
        check("flush_valid", 64'(bus.out_valid), 64'(0));
        cycle(1, I_DEP, 1, 0);
        check("flush_ready", 64'(last_ready), 64'(1));

        // Illegal opcode still produces a bundle.
        cycle(1, I_ILL, 1, 0);
        check("illegal_valid", 64'(bus.out_valid), 64'(1));
        check("illegal_bundle", dut_bundle(),
              64'({3'd0, 4'd4, 4'd0, 4'd11, 3'd0, 8'b0000_0001}));

        // Asynchronous reset in the middle of traffic.
        cycle(1, I_ADD, 1, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset", 64'({bus.out_valid, bus.halted, bus.retired}), 64'(0));
        check("async_bundle", dut_bundle(), 64'(0));
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Random traffic, HALT excluded.
        for (int i = 0; i < 300; i++) begin
            rnd_ins = 9'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rnd_ins[8:6] = 3'b001;
                rnd_ins[1:0] = 2'b00;
            end
            if (rnd_ins[8:6] == 3'b111) rnd_ins[8:6] = 3'b010;
            cycle($urandom_range(0, 3) != 0, rnd_ins, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0);
        end

        // HALT is delivered, then the stage stays closed.
        cycle(0, '0, 1, 0);
        cycle(1, I_HALT, 1, 0);
        check("halt_set", 64'(bus.halted), 64'(1));
        check("halt_valid", 64'(bus.out_valid), 64'(1));
        for (int i = 0; i < 20; i++) begin
            rnd_ins = 9'($urandom);
            cycle(1, rnd_ins, $urandom_range(0, 1) != 0, 0);
            check("halt_blocks", 64'(last_ready), 64'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised successor to the combinational 9-bit instruction decoder.
- Accepts one instruction per cycle over a valid/ready handshake and decodes it into the same control bundle.
- Holds the bundle in a one-entry output register for the execute stage.
- Adds load-use stall counting, sticky HALT, flush and a retired-instruction counter; sits between fetch and execute.

Parameters:
- NUM_REGS, 12, register file size; address width RA = $clog2(NUM_REGS).
- INSTR_WIDTH, 9, instruction width; opcode is the top 3 bits, fields are the low 6 bits.
- IMM_WIDTH, 3, width of the imm output (zero-extended).
- LOAD_DELAY, 1, cycles a dependent instruction is blocked after an LW is accepted (1..7).
- CNT_WIDTH, 16, width of retired counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage accepts this cycle
- instruction  in  INSTR_WIDTH  instruction word
- flush  in  1  discard output register and stall state
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute consumes bundle
- alu_op  out  3  0 AND, 1 SLT, 2 OR, 3 ADD, 4 SRL, 5 SRA, 6 PASS
- rs_addr, rt_addr, rd_addr  out  RA each  register addresses
- imm  out  IMM_WIDTH  immediate
- reg_read, reg_write, sel_imm, branch, mem_read, mem_write, mem2reg  out  1 each  control
- illegal  out  1  opcode 101/110 decoded
- halted  out  1  sticky HALT accepted
- retired  out  CNT_WIDTH  count of bundles consumed (out_valid && out_ready)

Behaviour:
- Reset (async, reset_n=0): every output register is 0, including out_valid, halted, retired, stall_cnt and all fields and controls. No X is ever driven on any output.
- Handshake:
  - in_ready = !halted && !hazard && (!out_valid || out_ready).
  - Accept = in_valid && in_ready. On accept the decoded bundle is registered and out_valid=1 on the next edge (latency 1).
  - If out_ready && !accept, out_valid goes to 0.
  - Output fields are held stable while out_valid && !out_ready.
- Decode (op = instruction[8:6]; f = instruction[5:0]):
  - Defaults: rs=f[5:4]+4, rt=f[3:2], rd=11, imm=0, all controls 0.
  - 000 (R-type, subop = f[1:0]): 00 AND, 01 SLT, 10 OR each set alu_op 0/1/2, reg_read=1, reg_write=1. 11 JR sets alu_op=6, reg_read=1, branch=1.
  - 001 (memory/shift, subop = f[1:0]):
    - 00 LW: alu_op=6, reg_read=1, mem_read=1, mem2reg=1, reg_write=1, rd=f[5:4]+4.
    - 01 SW: alu_op=6, reg_read=1, mem_write=1.
    - 10 SRL: alu_op=4, reg_read=1, reg_write=1.
    - 11 SRA: alu_op=5, reg_read=1, reg_write=1.
  - 010 ADD: alu_op=3, reg_read=1, reg_write=1, rd=f[1:0]+8.
  - 011 ADDI: alu_op=3, imm=f[1:0] zero-extended, sel_imm=1, reg_read=1, reg_write=1, rd=f[5:4]+4.
  - 100 TR: alu_op=6, rs=f[5:3], rd=f[2:0]+4, reg_read=1, reg_write=1.
  - 111 HALT: all controls 0; accepting it sets halted=1 on the same edge.
  - 101/110: all controls 0, illegal=1; the bundle is still emitted.
  - Address arithmetic is computed at RA width. Any result >= NUM_REGS is clamped to NUM_REGS-1.
- Load-use hazard:
  - Accepting an LW loads stall_cnt=LOAD_DELAY and lw_rd=its rd.
  - stall_cnt decrements by 1 each cycle while nonzero.
  - hazard = stall_cnt!=0 && incoming reads lw_rd. "Reads" means reg_read && (rs==lw_rd || (rt==lw_rd && !sel_imm)).
  - An independent instruction is accepted during the stall; stall_cnt keeps counting.
  - LW followed by LW reloads stall_cnt on the second accept.
- Flush (synchronous, highest priority):
  - Next edge: out_valid=0, stall_cnt=0, no accept that cycle.
  - retired still counts a handshake that occurs in the flush cycle.
  - halted is not cleared by flush.
- Halted: in_ready=0 permanently; the HALT bundle itself is still delivered downstream. Only reset_n clears halted.
- retired wraps modulo 2^CNT_WIDTH.
- Reset asserted mid-operation: outputs go to 0 immediately (asynchronous); the in-flight bundle is lost.

Decomposition:
- Shared package decode_pkg holds:
  - opcode and subop localparams;
  - alu_op enum (AND..PASS);
  - struct ctrl_t with alu_op, the three addresses, imm, the seven control bits and illegal.
- Sub-module decode_comb: pure combinational instruction -> ctrl_t. decode_stage instantiates it and owns the handshake, hazard counter, halt and retired counter.

Test Plan:
- ADD 9'b010_01_10_11, in_valid=1, out_ready=1 -> next cycle out_valid=1, alu_op=3, rs=5, rt=2, rd=11, reg_write=1; retired increments the following cycle.
- LW 9'b001_10_00_00 then ADD reading rs=6 (9'b010_10_01_00), LOAD_DELAY=1 -> ADD in_ready=0 for 1 cycle, then accepted; an independent ADD (rs=4, rt=1) is instead accepted back-to-back.
- out_ready=0 for 3 cycles with in_valid=1 -> bundle held stable, in_ready=0, retired unchanged; first bundle delivered when out_ready rises.
- HALT 9'b111_000000 -> halted=1 next cycle, HALT bundle out_valid=1, in_ready stays 0 for 20 cycles with in_valid=1.
- flush asserted the cycle after an LW accept -> out_valid=0 next cycle, dependent ADD accepted immediately (stall_cnt cleared).
- Opcode 9'b101_000000 -> illegal=1, all controls 0, out_valid=1; reset_n pulsed low mid-stream -> all outputs 0 asynchronously, retired=0.
